rom_streamer: RTL and testbench

Sequencer directly upstream of the combinational 8x8 `rom`. It drives the ROM address, captures the returned data, and streams a programmed run of words out over a valid/ready handshake. Once started, it walks `count` consecutive addresses from `base_addr`, wraps modulo ROM depth, marks the final word, and pulses `done` when that word has been consumed.

---
 rtl/rom_streamer_if.sv | 12 +
 rtl/rom_streamer.sv | 132 +++++++++++++
 tb/tb_rom_streamer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_streamer_if.sv
// Output stream bundle of rom_streamer: a word with last marker under a valid/ready handshake.
interface rom_streamer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/rom_streamer.sv
// Sequencer in front of a combinational ROM: walks a programmed run of addresses and streams the words out.
// Optional ROM_STREAMER_CHECKSUM_EN adds a running checksum of the accepted words.
module rom_streamer #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    rom_streamer_if.master    strm
`ifdef ROM_STREAMER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  remaining, remaining_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d, last_d, busy_d, done_d;
    logic              loadable;

    // The output register may take a new word when empty or being drained this cycle.
    assign loadable = !strm.out_valid || strm.out_ready;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        rom_addr_d  = rom_addr;
        data_d      = strm.out_data;
        valid_d     = strm.out_valid;
        last_d      = strm.out_last;
        busy_d      = busy;
        done_d      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        rom_addr_d  = base_addr;
                        remaining_d = count;
                        busy_d      = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (loadable) begin
                    data_d      = rom_data;
                    valid_d     = 1'b1;
                    last_d      = (remaining == CNT_W'(1));
                    rom_addr_d  = rom_addr + ADDR_W'(1);
                    remaining_d = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (strm.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            remaining      <= '0;
            rom_addr       <= '0;
            strm.out_data  <= '0;
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_d;
            remaining      <= remaining_d;
            rom_addr       <= rom_addr_d;
            strm.out_data  <= data_d;
            strm.out_valid <= valid_d;
            strm.out_last  <= last_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

`ifdef ROM_STREAMER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_d;

    // Cleared when a run is started, accumulates every accepted word.
    always_comb begin
        checksum_d = checksum;
        if (state == S_IDLE && start) begin
            checksum_d = '0;
        end else if (strm.out_valid && strm.out_ready) begin
            checksum_d = checksum + strm.out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else begin
            checksum <= checksum_d;
        end
    end
`endif
endmodule

// File: tb/tb_rom_streamer.sv
// Bench for rom_streamer: queue-based stream model checked every cycle plus directed literal expectations.
module tb_rom_streamer;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
`ifdef ROM_STREAMER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
    logic [DATA_W-1:0] mcsum = '0;
`endif

    rom_streamer_if #(.DATA_W(DATA_W)) strm ();

    rom_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .strm      (strm)
`ifdef ROM_STREAMER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // ROM model: rom[i] = A0 + i
    assign rom_data = 8'hA0 + 8'(rom_addr);

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } word_t;

    word_t      expq[$];
    logic [7:0] got[$];
    bit         mbusy = 1'b0;
    bit         exp_done = 1'b0;
    bit         prev_rst = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model compare: check outputs produced by the last edge, then predict the next edge.
    always @(negedge clk) begin
        word_t w;
        if (prev_rst) begin
            check("rst_valid", 32'(strm.out_valid), 0);
            check("rst_data", 32'(strm.out_data), 0);
            check("rst_last", 32'(strm.out_last), 0);
            check("rst_addr", 32'(rom_addr), 0);
        end
        check("busy", 32'(busy), 32'(mbusy));
        check("done", 32'(done), 32'(exp_done));
        if (!mbusy) check("idle_valid", 32'(strm.out_valid), 0);
        if (prev_stall) begin
            check("stall_valid", 32'(strm.out_valid), 1);
            check("stall_data", 32'(strm.out_data), 32'(prev_data));
            check("stall_last", 32'(strm.out_last), 32'(prev_last));
        end
`ifdef ROM_STREAMER_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(mcsum));
`endif
        exp_done   = 1'b0;
        prev_rst   = rst;
        prev_stall = !rst && strm.out_valid && !strm.out_ready;
        prev_data  = strm.out_data;
        prev_last  = strm.out_last;
        if (rst) begin
            expq.delete();
            mbusy = 1'b0;
`ifdef ROM_STREAMER_CHECKSUM_EN
            mcsum = '0;
`endif
        end else if (!mbusy && start) begin
`ifdef ROM_STREAMER_CHECKSUM_EN
            mcsum = '0;
`endif
            if (count == 0) begin
                exp_done = 1'b1;
            end else begin
                for (int i = 0; i < int'(count); i++) begin
                    w.data = 8'hA0 + 8'((int'(base_addr) + i) % 8);
                    w.last = (i == int'(count) - 1);
                    expq.push_back(w);
                end
                mbusy = 1'b1;
            end
        end else if (strm.out_valid && strm.out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %0h expected no word", strm.out_data);
            end else begin
                w = expq.pop_front();
                check("word_data", 32'(strm.out_data), 32'(w.data));
                check("word_last", 32'(strm.out_last), 32'(w.last));
                got.push_back(strm.out_data);
`ifdef ROM_STREAMER_CHECKSUM_EN
                mcsum = mcsum + strm.out_data;
`endif
                if (w.last) begin
                    mbusy    = 1'b0;
                    exp_done = 1'b1;
                end
            end
        end
    end

    task automatic start_run(input logic [2:0] b, input logic [3:0] c);
        got.delete();
        base_addr = b;
        count     = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Drive out_ready from pat (bit 0 first, then 1s) until done, bounded.
    task automatic drain(input logic [15:0] pat, input int patlen);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            strm.out_ready = (i < patlen) ? pat[i] : 1'b1;
            tick();
            if (done) seen = 1'b1;
        end
        check("drain_done", 32'(seen), 1);
    endtask

    initial begin
        logic [7:0] e2[8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        logic [7:0] e3[4] = '{8'hA6, 8'hA7, 8'hA0, 8'hA1};
        logic [7:0] e4[3] = '{8'hA2, 8'hA3, 8'hA4};
        logic [7:0] e5[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        int n;

        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; strm.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_addr", 32'(rom_addr), 0);
        check("reset_valid", 32'(strm.out_valid), 0);
        check("reset_data", 32'(strm.out_data), 0);
        check("reset_last", 32'(strm.out_last), 0);

        // count = 0: done pulse only
        start_run(3'd3, 4'd0);
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        tick();
        check("zero_done_end", 32'(done), 0);
        check("zero_valid", 32'(strm.out_valid), 0);

        // full ROM sweep
        strm.out_ready = 1'b1;
        start_run(3'd0, 4'd8);
        check("t2_addr", 32'(rom_addr), 0);
        check("t2_busy", 32'(busy), 1);
        tick();
        check("t2_first_valid", 32'(strm.out_valid), 1);
        check("t2_first_data", 32'(strm.out_data), 32'hA0);
        check("t2_first_last", 32'(strm.out_last), 0);
        drain(16'h0, 0);
        check("t2_count", 32'(got.size()), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) check("t2_word", 32'(got[i]), 32'(e2[i]));
`ifdef ROM_STREAMER_CHECKSUM_EN
        check("t2_checksum", 32'(checksum), 32'h1C);
`endif
        tick();
        check("t2_done_end", 32'(done), 0);

        // wrap around
        start_run(3'd6, 4'd4);
        drain(16'h0, 0);
        check("t3_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("t3_word", 32'(got[i]), 32'(e3[i]));

        // backpressure 1,0,0,1,0,1
        start_run(3'd2, 4'd3);
        drain(16'b101001, 6);
        check("t4_count", 32'(got.size()), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("t4_word", 32'(got[i]), 32'(e4[i]));

        // start while busy is ignored
        strm.out_ready = 1'b1;
        start_run(3'd1, 4'd4);
        tick();
        base_addr = 3'd7; count = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        drain(16'h0, 0);
        check("t5_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("t5_word", 32'(got[i]), 32'(e5[i]));

        // reset mid-run, then a single-word run
        strm.out_ready = 1'b1;
        start_run(3'd0, 4'd8);
        n = 0;
        while (got.size() < 2 && n < 50) begin tick(); n++; end
        check("t6_two_words", 32'(got.size()), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", 32'(busy), 0);
        check("t6_done", 32'(done), 0);
        check("t6_valid", 32'(strm.out_valid), 0);
        tick();
        check("t6_no_done", 32'(done), 0);
        start_run(3'd5, 4'd1);
        tick();
        check("t6_a5_valid", 32'(strm.out_valid), 1);
        check("t6_a5_data", 32'(strm.out_data), 32'hA5);
        check("t6_a5_last", 32'(strm.out_last), 1);
        drain(16'h0, 0);
        check("t6_count", 32'(got.size()), 1);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
